ycr_cclk_gate_ctrl_n: RTL
=========================

Name: ycr_cclk_gate_ctrl_n

Overview:
- Parametrised N-channel core-clock gate controller; successor to the fixed AES/FPU/core0/core1 gating top.
- Each channel gates one branch of core_clk_int using a per-channel mode, an idle-hysteresis counter, a masked wake-source set and a minimum-run wake window.
- Sits between the RISC-V clock-config register bank and the core, FPU and AES clock branches.
- Also reports per-channel gated status back to that register bank.

Parameters:
- NCH, 4, number of gated channels (1..16).
- WAKE_W, 3, number of wake sources (timer/ext/soft IRQ, etc.).
- CNT_W, 8, width of the idle-hysteresis counter and threshold.
- WAKE_CYC, 4, minimum enabled cycles after a wake before idle re-evaluation (>=1).

Ports:
- core_clk_int  in  1  core clock, ungated.
- rst_n  in  1  asynchronous active-low reset.
- ch_mode  in  2*NCH  per-channel mode: 0 always-on, 1 always-off, 2 auto-immediate, 3 auto-hysteresis.
- ch_idle_thr  in  CNT_W*NCH  per-channel idle cycles required before gating (mode 3).
- ch_wake_mask  in  WAKE_W*NCH  per-channel wake-source enable.
- dst_idle  in  NCH  destination idle/sleep, synchronous to core_clk_int.
- src_req  in  NCH  synchronous source request.
- wake_src  in  WAKE_W  asynchronous wake levels; synchronised internally.
- wakeup  out  NCH  wake indication to destination.
- clk_enb  out  NCH  registered clock enable.
- ch_gated  out  NCH  status: 1 = channel clock stopped.
- gclk  out  NCH  gated clock outputs.

Behaviour:
- Reset (rst_n low, asynchronous): clk_enb=all 1, wakeup=0, ch_gated=0, FSMs in RUN, counters 0. Clocks run at reset so cores can boot.
- wake_src passes through a 2-flop high synchroniser (reset 0). Per-channel wake_any = |(wake_sync & mask) | src_req.
- gclk[i] is ctech_clk_gate(GATE=clk_enb[i], CLK=core_clk_int). There is no combinational path from any input to GATE.
- Mode 0: clk_enb=1, FSM forced to RUN, wakeup=0.
- Mode 1: clk_enb=0, ch_gated=1, FSM forced to GATED, wakeup=0.
- Mode changes take effect on the next clock edge from any state. Leaving mode 1 for auto enters WAKE if wake_any is set, else GATED.
- Auto FSM (modes 2/3), states RUN, IDLE_WAIT, GATED, WAKE:
  - RUN: clk_enb=1. If dst_idle & !wake_any: mode 2 goes to GATED, mode 3 goes to IDLE_WAIT with cnt=0.
  - IDLE_WAIT: clk_enb=1, cnt++ per cycle. If !dst_idle or wake_any, go to RUN and clear cnt. When cnt==ch_idle_thr-1, go to GATED. thr=0 behaves as mode 2.
  - GATED: clk_enb=0, ch_gated=1. On wake_any, go to WAKE.
  - WAKE: clk_enb=1, wakeup=1, counter counts WAKE_CYC cycles, then go to RUN. Idle is ignored during the window. A wake arriving during the window does not restart it.
- The counter saturates and never wraps.
- Latency, src_req to clock: high while GATED gives clk_enb=1 on the next edge, so the first gclk pulse follows one cycle later.
- Latency, async wake to clock: 2 sync cycles + 1.
- Latency, entering GATED: clk_enb falls on the same edge as the GATED state entry.
- Simultaneous idle and wake in RUN/IDLE_WAIT: wake wins, stay in or return to RUN.
- Reset asserted mid-operation: immediate return to the reset values; clocks restart.

Decomposition:
- Package ycr_cclk_pkg: mode enum (CCLK_ON, CCLK_OFF, CCLK_AUTO, CCLK_AUTO_HYS) and FSM state enum.
- Sub-module ycr_cclk_gate_chan: one channel FSM, counter and ICG, instantiated NCH times via generate.
- The top holds only the wake synchroniser and the mask/OR logic.

Test Plan:
- Reset check: apply reset, then release with mode=0 -> clk_enb=4'hF, gclk toggling on all channels, wakeup=0.
- Mode 2 gating: ch0 mode 2, dst_idle[0]=1, src_req=0 -> clk_enb[0]=0 one edge later, ch_gated[0]=1. Then src_req[0]=1 -> clk_enb[0]=1 next edge, wakeup[0] high exactly 4 cycles.
- Mode 3 hysteresis: ch1 thr=10, idle held -> gated after exactly 10 cycles. Drop idle at cycle 6 -> counter clears and ch1 stays running.
- Async wake masking: ch2 gated, mask=3'b010, pulse wake_src[0] -> stays gated. Pulse wake_src[1] -> clk_enb[2]=1 three cycles after the pulse.
- Forced modes: switch ch3 mode to 1 while in WAKE -> gated next edge, wakeup=0. Switch back to 2 with no wake -> remains GATED.
- Reset mid-GATED on all channels -> clk_enb=all 1 immediately, FSMs in RUN.

Source files
------------

// File: rtl/ycr_cclk_pkg.sv
// Shared types for the N-channel core-clock gate controller.
package ycr_cclk_pkg;

  typedef enum logic [1:0] {
    CCLK_ON       = 2'd0,
    CCLK_OFF      = 2'd1,
    CCLK_AUTO     = 2'd2,
    CCLK_AUTO_HYS = 2'd3
  } cclk_mode_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_GATED     = 2'd2,
    ST_WAKE      = 2'd3
  } cclk_state_e;

endpackage

// File: rtl/ctech_clk_gate.sv
// Behavioural integrated clock gate: enable latched while CLK is low, glitch-free GCLK.
module ctech_clk_gate (
  input  logic GATE,
  input  logic CLK,
  output logic GCLK
);

  logic en_lat;

  always_latch begin
    if (!CLK) en_lat <= GATE;
  end

  assign GCLK = CLK & en_lat;

endmodule

// File: rtl/ycr_cclk_gate_chan.sv
// One gated clock channel: mode handling, auto-gating FSM with shared idle/wake counter, and ICG.
module ycr_cclk_gate_chan
  import ycr_cclk_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  cclk_mode_e       mode_i,
  input  logic [CNT_W-1:0] idle_thr_i,
  input  logic             dst_idle_i,
  input  logic             wake_any_i,
  output logic             wakeup_o,
  output logic             clk_enb_o,
  output logic             ch_gated_o,
  output logic             gclk_o
);

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  cclk_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] thr_last;
  logic             enb_q, enb_d;
  logic             gate_now;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      enb_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enb_q   <= enb_d;
    end
  end

  // Counter saturates at all-ones; a zero threshold degenerates to immediate gating.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign thr_last = idle_thr_i - 1'b1;
  assign gate_now = (mode_i == CCLK_AUTO) || (idle_thr_i == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (mode_i)
      CCLK_ON: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      CCLK_OFF: begin
        state_d = ST_GATED;
        cnt_d   = '0;
      end
      default: begin
        case (state_q)
          ST_RUN: begin
            if (dst_idle_i && !wake_any_i) begin
              state_d = gate_now ? ST_GATED : ST_IDLE_WAIT;
              cnt_d   = '0;
            end
          end
          ST_IDLE_WAIT: begin
            if (!dst_idle_i || wake_any_i) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else if (gate_now || (cnt_q >= thr_last)) begin
              state_d = ST_GATED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_GATED: begin
            if (wake_any_i) begin
              state_d = ST_WAKE;
              cnt_d   = '0;
            end
          end
          ST_WAKE: begin
            // Fixed run window; further wakes and idle are ignored until it expires.
            if (cnt_q >= WAKE_LAST) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end
    endcase
  end

  assign enb_d      = (state_d != ST_GATED);
  assign clk_enb_o  = enb_q;
  assign ch_gated_o = (state_q == ST_GATED);
  assign wakeup_o   = (state_q == ST_WAKE);

  ctech_clk_gate u_icg (
    .GATE (enb_q),
    .CLK  (clk_i),
    .GCLK (gclk_o)
  );

endmodule

// File: rtl/ycr_cclk_gate_ctrl_n.sv
// N-channel core-clock gate controller: wake synchroniser, per-channel wake masking, channel array.
module ycr_cclk_gate_ctrl_n
  import ycr_cclk_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WAKE_W   = 3,
  parameter int CNT_W    = 8,
  parameter int WAKE_CYC = 4
) (
  input  logic                  core_clk_int,
  input  logic                  rst_n,
  input  logic [2*NCH-1:0]      ch_mode,
  input  logic [CNT_W*NCH-1:0]  ch_idle_thr,
  input  logic [WAKE_W*NCH-1:0] ch_wake_mask,
  input  logic [NCH-1:0]        dst_idle,
  input  logic [NCH-1:0]        src_req,
  input  logic [WAKE_W-1:0]     wake_src,
  output logic [NCH-1:0]        wakeup,
  output logic [NCH-1:0]        clk_enb,
  output logic [NCH-1:0]        ch_gated,
  output logic [NCH-1:0]        gclk
);

  logic [WAKE_W-1:0] wake_meta_q, wake_sync_q;
  logic [NCH-1:0]    wake_any;

  always_ff @(posedge core_clk_int or negedge rst_n) begin
    if (!rst_n) begin
      wake_meta_q <= '0;
      wake_sync_q <= '0;
    end else begin
      wake_meta_q <= wake_src;
      wake_sync_q <= wake_meta_q;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign wake_any[gi] = (|(wake_sync_q & ch_wake_mask[gi*WAKE_W +: WAKE_W])) | src_req[gi];

    ycr_cclk_gate_chan #(
      .CNT_W    (CNT_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_chan (
      .clk_i      (core_clk_int),
      .rst_n_i    (rst_n),
      .mode_i     (cclk_mode_e'(ch_mode[2*gi +: 2])),
      .idle_thr_i (ch_idle_thr[gi*CNT_W +: CNT_W]),
      .dst_idle_i (dst_idle[gi]),
      .wake_any_i (wake_any[gi]),
      .wakeup_o   (wakeup[gi]),
      .clk_enb_o  (clk_enb[gi]),
      .ch_gated_o (ch_gated[gi]),
      .gclk_o     (gclk[gi])
    );
  end

endmodule
